// File: rtl/dot_board_scanner.sv
// ---------------------------------------------------------------------------
// dot_board_scanner
//
// Row-scan driver for the game-board dot-matrix display. A CELLS x CELLS board
// of 2-bit cell codes is drawn as 3x3 glyphs on a 4-dot pitch, so one board row
// occupies three display rows plus one blank spacer row. The image can be
// shifted down by row_offset dots. The cell under the cursor blinks solid when
// the highlight is enabled.
//
// The board, offset and cursor inputs are latched once per frame, on the edge
// where the scan wraps back to row 0. Row 0 of the new frame is drawn straight
// from the inputs on that edge. Every other row is drawn from the latched copy,
// so the game FSM can update the board at any time without tearing the image.
//
// Ports
//   freq        in   system clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   board       in   packed cell codes, cell r*CELLS+c at [2*idx+1:2*idx]
//                    (0 empty, 1 X, 2 O, 3 blank)
//   row_offset  in   vertical shift of the board image, in dots
//   cursor      in   highlighted cell index (>= CELLS*CELLS matches nothing)
//   cursor_en   in   enables the blinking cursor highlight
//   dot_row     out  one-hot strobe for the active display row
//   dot_col     out  column data for the active display row
//   frame_start out  one-cycle pulse in the first cycle of display row 0
// ---------------------------------------------------------------------------
module dot_board_scanner #(
  parameter int CLK_DIV      = 12500,
  parameter int ROWS         = 10,
  parameter int COLS         = 14,
  parameter int CELLS        = 3,
  parameter int OFS_W        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                               freq,
  input  logic                               rst,
  input  logic [2*CELLS*CELLS-1:0]           board,
  input  logic [OFS_W-1:0]                   row_offset,
  input  logic [$clog2(CELLS*CELLS)-1:0]     cursor,
  input  logic                               cursor_en,
  output logic [ROWS-1:0]                    dot_row,
  output logic [COLS-1:0]                    dot_col,
  output logic                               frame_start
);

  localparam int NCELL = CELLS * CELLS;
  localparam int BRD_W = 2 * NCELL;
  localparam int CUR_W = $clog2(NCELL);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Height of the drawn image in dots: CELLS glyph rows on a 4-dot pitch,
  // without the trailing spacer row.
  localparam int IMG_H = 4 * CELLS - 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic [ROW_W-1:0] row_idx_reg;
  logic [ROWS-1:0]  dot_row_reg;
  logic [COLS-1:0]  dot_col_reg;
  logic             frame_start_reg;
  logic [FRM_W-1:0] frame_cnt_reg;
  logic             blink_on_reg;
  logic [BRD_W-1:0] snap_board_reg;
  logic [OFS_W-1:0] snap_ofs_reg;
  logic [CUR_W-1:0] snap_cursor_reg;
  logic             snap_en_reg;

  // -------------------------------------------------------------------------
  // Scan timing
  // -------------------------------------------------------------------------
  logic             tick;
  logic             wrap;
  logic [ROW_W-1:0] row_idx_next;
  logic [FRM_W-1:0] frame_cnt_next;
  logic             blink_on_next;

  assign tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign wrap = tick && (row_idx_reg == ROW_W'(ROWS - 1));

  // Index of the row that becomes active on the next tick.
  assign row_idx_next = wrap ? '0 : row_idx_reg + ROW_W'(1);

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    blink_on_next  = blink_on_reg;
    if (wrap) begin
      if (frame_cnt_reg == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_next = '0;
        blink_on_next  = ~blink_on_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + FRM_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Render source: the wrap edge draws row 0 from the live inputs (the same
  // values being latched), every other tick draws from the latched copy.
  // The blink phase used is the one in force after this edge, which lets row 0
  // pick up a toggle happening on the same edge.
  // -------------------------------------------------------------------------
  logic [BRD_W-1:0] src_board;
  logic [OFS_W-1:0] src_ofs;
  logic [CUR_W-1:0] src_cursor;
  logic             src_en;
  logic             src_blink;

  assign src_board  = wrap ? board      : snap_board_reg;
  assign src_ofs    = wrap ? row_offset : snap_ofs_reg;
  assign src_cursor = wrap ? cursor     : snap_cursor_reg;
  assign src_en     = wrap ? cursor_en  : snap_en_reg;
  assign src_blink  = blink_on_next;

  // -------------------------------------------------------------------------
  // Row geometry. Everything is widened to 32 bits so that subtracting the
  // offset and comparing against the image height can never wrap around.
  // -------------------------------------------------------------------------
  logic [31:0] disp_row;
  logic [31:0] ofs_ext;
  logic [31:0] y_pos;
  logic        visible;
  logic [1:0]  slice;
  logic [31:0] cell_base;

  assign disp_row = 32'(row_idx_next);
  assign ofs_ext  = 32'(src_ofs);
  assign y_pos    = disp_row - ofs_ext;
  assign visible  = (disp_row >= ofs_ext) &&
                    (y_pos < 32'(IMG_H)) &&
                    (y_pos[1:0] != 2'd3);
  // Dot row within the glyph: 0..2 whenever the row is visible.
  assign slice    = y_pos[1:0];
  // First cell index of the board row being drawn; forced to 0 for invisible
  // rows so that the cell lookup below always stays inside the board vector.
  assign cell_base = visible ? (y_pos >> 2) * 32'(CELLS) : 32'd0;

  // -------------------------------------------------------------------------
  // Per-cell glyph lookup
  // -------------------------------------------------------------------------
  logic [3*CELLS-1:0] glyph_vec;

  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
      logic [31:0] cell_idx;
      logic [1:0]  code;
      logic        hit;
      logic [2:0]  glyph;

      assign cell_idx = cell_base + 32'(gi);
      assign code     = src_board[2*cell_idx +: 2];
      assign hit      = src_en && src_blink && (cell_idx == 32'(src_cursor));

      always_comb begin
        glyph = 3'b000;
        if (hit) begin
          glyph = 3'b111;
        end else begin
          case (code)
            2'd1:    glyph = (slice == 2'd1) ? 3'b010 : 3'b101;  // X
            2'd2:    glyph = (slice == 2'd1) ? 3'b101 : 3'b010;  // O
            default: glyph = 3'b000;                             // empty / blank
          endcase
        end
      end

      assign glyph_vec[3*gi +: 3] = visible ? glyph : 3'b000;
    end
  endgenerate

  // Spread the 3-dot glyphs onto the 4-dot column pitch; spacer columns and
  // any columns right of the image stay dark.
  logic [COLS-1:0] col_next;

  always_comb begin
    col_next = '0;
    for (int c = 0; c < CELLS; c++) begin
      col_next[4*c +: 3] = glyph_vec[3*c +: 3];
    end
  end

  // One-hot row strobe for the row about to become active.
  logic [ROWS-1:0] row_next;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_next[gi] = (row_idx_next == ROW_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge freq) begin
    if (rst) begin
      div_cnt_reg     <= '0;
      row_idx_reg     <= '0;
      dot_row_reg     <= ROWS'(1);
      dot_col_reg     <= '0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
      blink_on_reg    <= 1'b0;
      snap_board_reg  <= '0;
      snap_ofs_reg    <= '0;
      snap_cursor_reg <= '0;
      snap_en_reg     <= 1'b0;
    end else begin
      div_cnt_reg     <= tick ? '0 : div_cnt_reg + DIV_W'(1);
      frame_start_reg <= wrap;
      frame_cnt_reg   <= frame_cnt_next;
      blink_on_reg    <= blink_on_next;
      if (tick) begin
        row_idx_reg <= row_idx_next;
        dot_row_reg <= row_next;
        dot_col_reg <= col_next;
      end
      if (wrap) begin
        snap_board_reg  <= board;
        snap_ofs_reg    <= row_offset;
        snap_cursor_reg <= cursor;
        snap_en_reg     <= cursor_en;
      end
    end
  end

  assign dot_row     = dot_row_reg;
  assign dot_col     = dot_col_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_dot_board_scanner.sv
// ---------------------------------------------------------------------------
// tb_dot_board_scanner
//
// Self-checking bench for dot_board_scanner (CLK_DIV=4, ROWS=10, COLS=14,
// CELLS=3, BLINK_FRAMES=2). A reference model derives the expected outputs
// from the cycle count since reset and the frame-latched inputs, and one
// compare process checks every cycle. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_dot_board_scanner;

  localparam int CLK_DIV      = 4;
  localparam int ROWS         = 10;
  localparam int COLS         = 14;
  localparam int CELLS        = 3;
  localparam int OFS_W        = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = CLK_DIV * ROWS;
  localparam int BRD_W        = 2 * CELLS * CELLS;

  logic              freq = 1'b0;
  logic              rst = 1'b1;
  logic [BRD_W-1:0]  board = '0;
  logic [OFS_W-1:0]  row_offset = '0;
  logic [3:0]        cursor = '0;
  logic              cursor_en = 1'b0;
  logic [ROWS-1:0]   dot_row;
  logic [COLS-1:0]   dot_col;
  logic              frame_start;

  int n_cmp = 0;
  int n_fail = 0;
  int n_print = 0;

  dot_board_scanner #(
    .CLK_DIV(CLK_DIV), .ROWS(ROWS), .COLS(COLS), .CELLS(CELLS),
    .OFS_W(OFS_W), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .freq(freq), .rst(rst), .board(board), .row_offset(row_offset),
    .cursor(cursor), .cursor_en(cursor_en), .dot_row(dot_row),
    .dot_col(dot_col), .frame_start(frame_start)
  );

  initial forever #5 freq = ~freq;

  // Expected column pattern for display row d, straight from the glyph rules.
  function automatic logic [COLS-1:0] render(int d, logic [BRD_W-1:0] b, int ofs,
                                             int cur, bit en, bit blk);
    logic [COLS-1:0] v;
    logic [1:0] code;
    logic [2:0] g;
    int y, r, s, idx;
    v = '0;
    if (d < ofs) return v;
    y = d - ofs;
    if (y >= 4*CELLS-1 || y % 4 == 3) return v;
    r = y / 4;
    s = y % 4;
    for (int c = 0; c < CELLS; c++) begin
      idx  = r*CELLS + c;
      code = b[2*idx +: 2];
      if (en && blk && idx == cur)  g = 3'b111;
      else if (code == 2'd1)        g = (s == 1) ? 3'b010 : 3'b101;
      else if (code == 2'd2)        g = (s == 1) ? 3'b101 : 3'b010;
      else                          g = 3'b000;
      v[4*c +: 3] = g;
    end
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got none expected event", name);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit               valid = 1'b0;
  int               n = 0;
  logic [BRD_W-1:0] s_board = '0;
  int               s_ofs = 0;
  int               s_cur = 0;
  bit               s_en = 1'b0;
  logic [ROWS-1:0]  exp_row;
  logic [COLS-1:0]  exp_col;
  logic             exp_fs;

  initial forever begin
    int row, f;
    bit blk;
    @(posedge freq);
    if (rst) begin
      valid = 1'b1; n = 0;
      s_board = '0; s_ofs = 0; s_cur = 0; s_en = 1'b0;
    end else if (valid) begin
      n++;
      if (n % FRAME == 0) begin
        s_board = board; s_ofs = int'(row_offset);
        s_cur = int'(cursor); s_en = cursor_en;
      end
    end
    if (valid) begin
      row = (n / CLK_DIV) % ROWS;
      f   = n / FRAME;
      blk = ((f / BLINK_FRAMES) % 2) == 1;
      exp_row = '0;
      exp_row[row] = 1'b1;
      exp_col = render(row, s_board, s_ofs, s_cur, s_en, blk);
      exp_fs  = (n > 0) && (n % FRAME == 0);
    end
    #1;
    if (valid) begin
      n_cmp += 3;
      if (dot_row !== exp_row || dot_col !== exp_col || frame_start !== exp_fs) begin
        if (dot_row !== exp_row) n_fail++;
        if (dot_col !== exp_col) n_fail++;
        if (frame_start !== exp_fs) n_fail++;
        if (n_print < 40) begin
          n_print++;
          $display("FAIL cycle n=%0d: got row=%h col=%h fs=%b expected row=%h col=%h fs=%b",
                   n, dot_row, dot_col, frame_start, exp_row, exp_col, exp_fs);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fs(output int cyc);
    cyc = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      @(negedge freq);
      cyc++;
      if (frame_start === 1'b1) return;
    end
    timeout("wait_frame_start");
  endtask

  task automatic wait_row(input int k);
    logic [ROWS-1:0] tgt;
    tgt = '0;
    tgt[k] = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge freq);
      if (dot_row === tgt) return;
    end
    timeout("wait_row");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    logic [COLS-1:0] blink_exp [4];
    blink_exp[0] = 14'h000; blink_exp[1] = 14'h070;
    blink_exp[2] = 14'h070; blink_exp[3] = 14'h000;

    repeat (3) @(negedge freq);
    chk("reset_row", 32'(dot_row), 32'h1);
    chk("reset_col", 32'(dot_col), 32'h0);
    rst = 1'b0;

    // Free run: frame_start period and coincidence with row 0.
    wait_fs(c);
    wait_fs(c);
    chk("fs_period", c, FRAME);
    chk("fs_row0", 32'(dot_row), 32'h1);

    // X in cell 0, O in cell 1.
    board = 18'h00009;
    wait_fs(c);
    chk("xo_row0", 32'(dot_col), 32'h025);
    wait_row(1);
    chk("xo_row1", 32'(dot_col), 32'h052);
    wait_row(3);
    chk("xo_row3", 32'(dot_col), 32'h000);

    // Mid-frame change is invisible until the next frame.
    board = 18'h00040;
    wait_fs(c);
    wait_row(5);
    board = 18'h00080;
    wait_row(6);
    chk("tear_row6_old", 32'(dot_col), 32'h005);
    wait_fs(c);
    wait_row(4);
    chk("tear_row4_new", 32'(dot_col), 32'h002);

    // Vertical offset of one dot.
    board = 18'h00040;
    row_offset = 2'd1;
    wait_fs(c);
    chk("ofs_row0", 32'(dot_col), 32'h000);
    wait_row(5);
    chk("ofs_row5", 32'(dot_col), 32'h005);
    wait_row(6);
    chk("ofs_row6", 32'(dot_col), 32'h002);
    wait_row(9);
    chk("ofs_row9", 32'(dot_col), 32'h000);

    // Reset at row 6, then cursor blink phase from a fresh start.
    board = '0;
    row_offset = '0;
    cursor = 4'd4;
    cursor_en = 1'b1;
    wait_fs(c);
    wait_row(6);
    rst = 1'b1;
    @(negedge freq);
    chk("midrst_row", 32'(dot_row), 32'h1);
    chk("midrst_col", 32'(dot_col), 32'h0);
    chk("midrst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_fs(c);
      wait_row(5);
      chk("blink_row5", 32'(dot_col), 32'(blink_exp[f]));
    end

    // Out-of-range cursor never lights.
    cursor = 4'd9;
    for (int f = 0; f < 3; f++) begin
      wait_fs(c);
      wait_row(5);
      chk("cursor9_row5", 32'(dot_col), 32'h000);
    end

    // Randomized run with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      @(negedge freq);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        board      = BRD_W'($urandom());
        row_offset = OFS_W'($urandom_range(0, 3));
        cursor     = 4'($urandom_range(0, 15));
        cursor_en  = ($urandom_range(0, 3) != 0);
      end
    end
    rst = 1'b0;
    repeat (FRAME) @(negedge freq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
